adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
Multi-cycle add/subtract sequencer that time-shares a single adder_4bit slice to produce WIDTH-bit results, one nibble per clock, LSB nibble first. It latches operands through a valid/ready input handshake and holds the result and flags behind a valid/ready output handshake. It serves the ALU path wherever area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, derived (localparam) number of slice passes per operation.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and op present.
in_ready  output  1  controller can accept an operation.
op_sub  input  1  0 = A+B, 1 = A-B, computed as A + ~B + 1.
a_in  input  WIDTH  operand A.
b_in  input  WIDTH  operand B.
flush  input  1  synchronous abort of any operation in flight.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  sum/difference.
cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
ovfl  output  1  signed overflow of the MSB slice.
zero  output  1  result == 0.
busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; nibble counter 0; result, cout, ovfl, zero, out_valid, busy all 0; in_ready 1 after release.
- Three states:
  - IDLE: in_ready=1. On in_valid at a rising edge, latch a_in, b_in XOR {WIDTH{op_sub}} and carry=op_sub. Clear counter. Go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle, slice inputs are A[4i+3:4i], B'[4i+3:4i] and the carry register, with i = counter. At the edge, the slice Sum is written to result[4i+3:4i] and the slice Cout to the carry register, and the counter increments. At the edge with i = NIB-1, also capture cout and ovfl from that slice, compute zero from the full result including the new nibble, and go to DONE.
  - DONE: out_valid=1, in_ready=0. Result and flags are held stable until an edge with out_ready=1, then go to IDLE with out_valid=0. No back-to-back acceptance: a new operation is accepted only once back in IDLE.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 cycles at WIDTH=16). Throughput is one operation per NIB+2 cycles with out_ready tied high.
- Slice P/G outputs are unused. The slice ovfl output is honoured only on the last pass.
- Width rules: operands are two's complement for ovfl and unsigned for cout. Result wraps modulo 2^WIDTH.
- flush: synchronous, highest priority over every state transition. The next state is IDLE, out_valid=0, busy=0, counter cleared. Result and flags are cleared to 0. A flush in IDLE that coincides with in_valid drops that operation (in_ready is still 1, but no operation is accepted).
- Reset asserted mid-RUN or in DONE aborts immediately with no partial result visible. Operand changes on a_in/b_in after acceptance have no effect.
- out_ready in IDLE or RUN is ignored. in_valid outside IDLE is ignored and must be held by the producer until in_ready.

Test Plan:
- WIDTH=16, add 0x7FFF + 0x0001 -> after 4 cycles out_valid=1, result=0x8000, ovfl=1, cout=0, zero=0.
- Add 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovfl=0, zero=1. Carry ripples across all four passes.
- Subtract 0x0005 - 0x0005 -> result=0x0000, cout=1, zero=1. Subtract 0x8000 - 0x0001 -> result=0x7FFF, ovfl=1, cout=1. Subtract 0x0000 - 0x0001 -> result=0xFFFF, cout=0.
- Output backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0. Pulse out_ready -> IDLE next edge, in_ready=1. Change a_in during RUN -> result unaffected.
- flush asserted on the 2nd RUN cycle -> IDLE next edge, out_valid never rises, result=0. The next operation 0x1234 + 0x1111 yields 0x2345.
- rst_n pulsed low asynchronously mid-RUN -> all outputs 0 immediately. After release, in_ready=1 and a fresh 0x00FF + 0x0001 yields 0x0100 with latency 4. Repeat with WIDTH=4 and WIDTH=8 for latency 1 and 2.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice is reused NIB times,
// LSB nibble first, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | ready for a new operation, in_ready high
// RUN   | one slice pass per clock, busy high
// DONE  | result and flags held until out_ready

module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       ovfl
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign ovfl        = (a[3] == b[3]) && (sum[3] != a[3]);
endmodule

module adder_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovfl,
   output logic             zero,
   output logic             busy
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, result_q, result_new;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, ovfl_q, zero_q;
   logic [3:0]       a_nib, b_nib, s_sum;
   logic             s_cout, s_ovfl, last;

   adder_4bit u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout),
      .ovfl (s_ovfl)
   );

   assign last = (cnt_q == LAST);

   // pick the operand nibbles addressed by the pass counter
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIB; i++) begin
         if (cnt_q == CW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   // result with the current slice sum merged into its nibble position
   always_comb begin
      result_new = result_q;
      for (int i = 0; i < NIB; i++) begin
         if (cnt_q == CW'(i)) result_new[4*i +: 4] = s_sum;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state and handshake outputs; flush overrides every transition
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // operand capture, nibble-serial accumulation and flag capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovfl_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (flush) begin
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovfl_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a_in;
                  // subtract is A + ~B + 1: invert B here, the +1 rides in as carry
                  b_q     <= b_in ^ {WIDTH{op_sub}};
                  carry_q <= op_sub;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               result_q <= result_new;
               carry_q  <= s_cout;
               if (last) begin
                  cnt_q  <= '0;
                  cout_q <= s_cout;
                  ovfl_q <= s_ovfl;
                  zero_q <= (result_new == '0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign ovfl   = ovfl_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: WIDTH=16 main instance plus WIDTH=8 and WIDTH=4
// instances for the latency scaling.

module tb_adder_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_sub, flush, out_ready;
   logic [15:0] a_in, b_in;
   logic        in_valid_v [3];
   logic        in_ready_v [3];
   logic        out_valid_v[3];
   logic        busy_v     [3];
   logic        cout_v     [3];
   logic        ovfl_v     [3];
   logic        zero_v     [3];
   logic [15:0] res16;
   logic [7:0]  res8;
   logic [3:0]  res4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_seq_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .op_sub(op_sub), .a_in(a_in), .b_in(b_in), .flush(flush),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .result(res16),
      .cout(cout_v[0]), .ovfl(ovfl_v[0]), .zero(zero_v[0]), .busy(busy_v[0]));

   adder_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .op_sub(op_sub), .a_in(a_in[7:0]), .b_in(b_in[7:0]), .flush(flush),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .result(res8),
      .cout(cout_v[1]), .ovfl(ovfl_v[1]), .zero(zero_v[1]), .busy(busy_v[1]));

   adder_seq_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .op_sub(op_sub), .a_in(a_in[3:0]), .b_in(b_in[3:0]), .flush(flush),
      .out_valid(out_valid_v[2]), .out_ready(out_ready), .result(res4),
      .cout(cout_v[2]), .ovfl(ovfl_v[2]), .zero(zero_v[2]), .busy(busy_v[2]));

   function automatic int width_of(input int k);
      return (k == 0) ? 16 : (k == 1) ? 8 : 4;
   endfunction

   function automatic logic [15:0] get_res(input int k);
      case (k)
         0:       return res16;
         1:       return {8'h00, res8};
         default: return {12'h000, res4};
      endcase
   endfunction

   // reference: plain integer arithmetic on unsigned and signed views
   function automatic void model(input int w, input logic op, input logic [15:0] a, b,
                                 output logic [15:0] r, output logic c, v, z);
      longint m, ua, ub, sa, sb, ex, lim;
      m   = (longint'(1) << w) - 1;
      lim = longint'(1) << (w - 1);
      ua  = longint'(a) & m;
      ub  = longint'(b) & m;
      sa  = (ua >= lim) ? ua - (m + 1) : ua;
      sb  = (ub >= lim) ? ub - (m + 1) : ub;
      if (op) begin
         r  = 16'((ua - ub) & m);
         c  = (ua >= ub);
         ex = sa - sb;
      end else begin
         r  = 16'((ua + ub) & m);
         c  = ((ua + ub) > m);
         ex = sa + sb;
      end
      v = (ex < -lim) || (ex >= lim);
      z = (r == 16'h0000);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // full operation: accept, measure latency, check, hold under backpressure, release
   task automatic run_op(input int k, input logic op, input logic [15:0] a, b,
                         input logic [15:0] er, input logic ec, ev, ez,
                         input int hold, input string tag);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready_idle"}, in_ready_v[k], 1);
      in_valid_v[k] = 1'b1;
      op_sub = op;
      a_in = a;
      b_in = b;
      @(posedge clk); #1;
      in_valid_v[k] = 1'b0;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      op_sub = 1'($urandom);
      check({tag, "_busy"}, busy_v[k], 1);
      check({tag, "_in_ready_run"}, in_ready_v[k], 0);
      lat = 0;
      while (!out_valid_v[k] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, width_of(k) / 4);
      check({tag, "_result"}, get_res(k), er);
      check({tag, "_cout"}, cout_v[k], ec);
      check({tag, "_ovfl"}, ovfl_v[k], ev);
      check({tag, "_zero"}, zero_v[k], ez);
      repeat (hold) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, out_valid_v[k], 1);
         check({tag, "_hold_result"}, get_res(k), er);
         check({tag, "_hold_flags"}, {cout_v[k], ovfl_v[k], zero_v[k]}, {ec, ev, ez});
         check({tag, "_hold_in_ready"}, in_ready_v[k], 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_released_valid"}, out_valid_v[k], 0);
      check({tag, "_released_in_ready"}, in_ready_v[k], 1);
   endtask

   task automatic run_model(input int k, input logic op, input logic [15:0] a, b,
                            input int hold, input string tag);
      logic [15:0] r;
      logic c, v, z;
      model(width_of(k), op, a, b, r, c, v, z);
      run_op(k, op, a, b, r, c, v, z, hold, tag);
   endtask

   typedef struct {
      logic        op;
      logic [15:0] a, b, r;
      logic        c, v, z;
      int          hold;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic seen;
      vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 0};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 0};
      vecs[2] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1};
      vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0};
      vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 5};
      vecs[5] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 2};

      rst_n = 1'b0;
      op_sub = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      a_in = '0;
      b_in = '0;
      for (int k = 0; k < 3; k++) in_valid_v[k] = 1'b0;
      #23;
      check("reset_result", res16, 0);
      check("reset_out_valid", out_valid_v[0], 0);
      check("reset_busy", busy_v[0], 0);
      check("reset_flags", {cout_v[0], ovfl_v[0], zero_v[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("post_reset_in_ready", in_ready_v[k], 1);

      for (int i = 0; i < 6; i++)
         run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].hold, $sformatf("vec%0d", i));

      // flush on the second RUN cycle
      @(negedge clk);
      in_valid_v[0] = 1'b1; op_sub = 1'b0; a_in = 16'hFFFF; b_in = 16'h0001;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_run_busy", busy_v[0], 0);
      check("flush_run_in_ready", in_ready_v[0], 1);
      check("flush_run_result", res16, 0);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid_v[0]) seen = 1'b1;
      end
      check("flush_run_no_valid", seen, 0);
      run_op(0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 0, "after_flush");

      // flush coinciding with in_valid in IDLE drops the operation
      @(negedge clk);
      in_valid_v[0] = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0; flush = 1'b0;
      check("flush_idle_busy", busy_v[0], 0);
      check("flush_idle_in_ready", in_ready_v[0], 1);
      check("flush_idle_result", res16, 0);

      // flush in DONE clears held result and flags
      @(negedge clk);
      in_valid_v[0] = 1'b1; op_sub = 1'b0; a_in = 16'hFFFF; b_in = 16'h0001;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_flush_done_valid", out_valid_v[0], 1);
      check("pre_flush_done_flags", {cout_v[0], zero_v[0]}, 2'b11);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_done_valid", out_valid_v[0], 0);
      check("flush_done_flags", {cout_v[0], ovfl_v[0], zero_v[0]}, 0);
      check("flush_done_in_ready", in_ready_v[0], 1);

      // asynchronous reset mid-RUN
      @(negedge clk);
      in_valid_v[0] = 1'b1; op_sub = 1'b0; a_in = 16'h1234; b_in = 16'h0101;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk); #3;
      check("pre_reset_busy", busy_v[0], 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_result", res16, 0);
      check("async_reset_valid", out_valid_v[0], 0);
      check("async_reset_busy", busy_v[0], 0);
      check("async_reset_flags", {cout_v[0], ovfl_v[0], zero_v[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 0, "post_reset");

      // narrower instances
      run_model(1, 1'b0, 16'h00FF, 16'h0001, 0, "w8_add");
      run_model(1, 1'b1, 16'h0080, 16'h0001, 1, "w8_sub");
      run_model(2, 1'b0, 16'h0007, 16'h0001, 0, "w4_add");
      run_model(2, 1'b1, 16'h0003, 16'h0005, 2, "w4_sub");

      // randomized operations against the reference
      for (int n = 0; n < 40; n++) begin
         int k;
         k = int'($urandom_range(2, 0));
         run_model(k, 1'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(2, 0)), $sformatf("rand%0d_w%0d", n, width_of(k)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
      $fatal(1);
   end

endmodule
